// File: rtl/vjtag_regctl_pkg.sv
// Shared constants for the virtual-JTAG register-map controller:
// register addresses, command bit positions and the clear FSM encoding.
package vjtag_regctl_pkg;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_CMD      = 8'h01;
    localparam logic [7:0] ADDR_CTRL     = 8'h02;
    localparam logic [7:0] ADDR_PRESCALE = 8'h03;
    localparam logic [7:0] ADDR_SNAP0    = 8'h04;
    localparam logic [7:0] ADDR_SNAP1    = 8'h05;
    localparam logic [7:0] ADDR_SNAP2    = 8'h06;
    localparam logic [7:0] ADDR_SNAP3    = 8'h07;

    // Bit positions inside a CMD write
    localparam int CMD_SOFT_RST = 0;
    localparam int CMD_CLEAR    = 1;
    localparam int CMD_SNAP     = 2;

    // Bit positions inside CTRL
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_AUTOINC = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vjtag_clr_seq.sv
// Counter-clear sequencer: a start pulse in IDLE holds cnt_clear and busy
// high for exactly CLR_LEN cycles; starts while busy are ignored here.
module vjtag_clr_seq #(
    parameter int CLR_LEN = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic i_start,
    output logic o_busy,
    output logic o_cnt_clear
);
    import vjtag_regctl_pkg::*;

    localparam logic [7:0] LP_CLR_LEN = 8'(CLR_LEN);

    clr_state_t r_state;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_cnt_clear;

    // Down-counter FSM; outputs registered so they change with the state
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_cnt_clear <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state     <= ST_CLEAR;
                        r_cnt       <= LP_CLR_LEN;
                        r_busy      <= 1'b1;
                        r_cnt_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Count value 1 is the last cycle with clear asserted
                    if (r_cnt <= 8'd1) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cnt_clear <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cnt_clear <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_cnt_clear = r_cnt_clear;

endmodule

// File: rtl/vjtag_regctl.sv
// Register-map controller between the virtual-JTAG byte interface and the
// 32-bit counter core. Owns the address pointer, write decode, snapshot
// capture and the registered readback mux; the clear timing lives in
// vjtag_clr_seq.
module vjtag_regctl #(
    parameter logic [7:0] ID_VALUE     = 8'hC3,
    parameter int         CLR_LEN      = 4,
    parameter logic [7:0] PRESCALE_RST = 8'h00
) (
    input  logic        tck,
    input  logic        init,
    input  logic [7:0]  address,
    input  logic [7:0]  wdata,
    input  logic        addr_we,
    input  logic        we,
    input  logic        rd,
    input  logic [31:0] count_in,
    output logic [7:0]  rdata,
    output logic        cnt_enable,
    output logic        cnt_clear,
    output logic [7:0]  prescale,
    output logic        busy
);
    import vjtag_regctl_pkg::*;

    logic [7:0]  r_ptr;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_prescale;
    logic [31:0] r_snap;
    logic        r_snap_valid;
    logic        r_err;
    logic [7:0]  r_rdata;

    logic        w_busy;
    logic        w_cnt_clear;
    logic        w_wr_cmd;
    logic        w_soft_rst;
    logic        w_clr_req;
    logic        w_snap_req;
    logic        w_clr_start;
    logic        w_srst;
    logic [7:0]  w_rd_mux;

    // Command decode; soft reset masks the clear and snapshot bits
    assign w_wr_cmd    = we && (r_ptr == ADDR_CMD);
    assign w_soft_rst  = w_wr_cmd && wdata[CMD_SOFT_RST];
    assign w_clr_req   = w_wr_cmd && !wdata[CMD_SOFT_RST] && wdata[CMD_CLEAR];
    assign w_snap_req  = w_wr_cmd && !wdata[CMD_SOFT_RST] && wdata[CMD_SNAP];
    assign w_clr_start = w_clr_req && !w_busy;
    assign w_srst      = init || w_soft_rst;

    vjtag_clr_seq #(
        .CLR_LEN (CLR_LEN)
    ) u_clr_seq (
        .clk         (tck),
        .srst        (w_srst),
        .i_start     (w_clr_start),
        .o_busy      (w_busy),
        .o_cnt_clear (w_cnt_clear)
    );

    // Readback mux, evaluated against the current pointer and registers
    always_comb begin
        w_rd_mux = 8'h00;
        case (r_ptr)
            ADDR_ID:       w_rd_mux = ID_VALUE;
            ADDR_CMD:      w_rd_mux = {5'b0, r_err, w_busy, r_snap_valid};
            ADDR_CTRL:     w_rd_mux = r_ctrl;
            ADDR_PRESCALE: w_rd_mux = r_prescale;
            ADDR_SNAP0:    w_rd_mux = r_snap[7:0];
            ADDR_SNAP1:    w_rd_mux = r_snap[15:8];
            ADDR_SNAP2:    w_rd_mux = r_snap[23:16];
            ADDR_SNAP3:    w_rd_mux = r_snap[31:24];
            default:       w_rd_mux = 8'h00;
        endcase
    end

    // Pointer, register writes, snapshot, error flag and registered rdata
    always_ff @(posedge tck) begin
        if (w_srst) begin
            r_ptr        <= 8'h00;
            r_ctrl       <= 8'h00;
            r_prescale   <= PRESCALE_RST;
            r_snap       <= 32'h0;
            r_snap_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= ID_VALUE;
        end else begin
            // Address load beats autoinc; writes always use the old pointer
            if (addr_we) begin
                r_ptr <= address;
            end else if (r_ctrl[CTRL_AUTOINC] && (we || rd)) begin
                r_ptr <= r_ptr + 8'd1;
            end

            if (we && (r_ptr == ADDR_CTRL)) begin
                r_ctrl <= wdata;
            end
            if (we && (r_ptr == ADDR_PRESCALE)) begin
                r_prescale <= wdata;
            end

            // A started clear invalidates the snapshot and drops any
            // snapshot request in the same write
            if (w_clr_start) begin
                r_snap_valid <= 1'b0;
            end else if (w_snap_req && !w_busy) begin
                r_snap       <= count_in;
                r_snap_valid <= 1'b1;
            end

            if (((w_clr_req || w_snap_req) && w_busy) || (w_clr_start && w_snap_req)) begin
                r_err <= 1'b1;
            end

            r_rdata <= w_rd_mux;
        end
    end

    assign rdata      = r_rdata;
    assign cnt_enable = r_ctrl[CTRL_ENABLE];
    assign prescale   = r_prescale;
    assign cnt_clear  = w_cnt_clear;
    assign busy       = w_busy;

endmodule

// File: tb/tb_vjtag_regctl.sv
// Directed bench for vjtag_regctl: inputs change on the falling edge,
// outputs are checked on the falling edge, one line per transaction.
module tb_vjtag_regctl;

    logic        tck;
    logic        init;
    logic [7:0]  address;
    logic [7:0]  wdata;
    logic        addr_we;
    logic        we;
    logic        rd;
    logic [31:0] count_in;
    logic [7:0]  rdata;
    logic        cnt_enable;
    logic        cnt_clear;
    logic [7:0]  prescale;
    logic        busy;

    int n_tests;
    int n_fail;

    vjtag_regctl #(
        .ID_VALUE     (8'hC3),
        .CLR_LEN      (4),
        .PRESCALE_RST (8'h00)
    ) dut (
        .tck        (tck),
        .init       (init),
        .address    (address),
        .wdata      (wdata),
        .addr_we    (addr_we),
        .we         (we),
        .rd         (rd),
        .count_in   (count_in),
        .rdata      (rdata),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .prescale   (prescale),
        .busy       (busy)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic tick();
        @(negedge tck);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_addr(input logic [7:0] a);
        address = a;
        addr_we = 1'b1;
        tick();
        addr_we = 1'b0;
        $display("[TB] addr_we 0x%02h", a);
    endtask

    task automatic do_we(input logic [7:0] d);
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        $display("[TB] we      0x%02h", d);
    endtask

    task automatic do_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        $display("[TB] rd      rdata=0x%02h", rdata);
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        int n_clr;
        int n_busy;

        n_tests  = 0;
        n_fail   = 0;
        init     = 1'b1;
        address  = 8'h00;
        wdata    = 8'h00;
        addr_we  = 1'b0;
        we       = 1'b0;
        rd       = 1'b0;
        count_in = 32'h0;

        // Reset for two cycles
        tick();
        tick();
        init = 1'b0;
        $display("[TB] reset released");
        chk("rst_rdata",      rdata,      8'hC3);
        chk("rst_cnt_enable", cnt_enable, 1'b0);
        chk("rst_cnt_clear",  cnt_clear,  1'b0);
        chk("rst_prescale",   prescale,   8'h00);
        chk("rst_busy",       busy,       1'b0);

        // CTRL write, then readback
        do_addr(8'h02);
        do_we(8'h03);
        chk("ctrl_enable", cnt_enable, 1'b1);
        do_addr(8'h02);
        tick();
        chk("ctrl_readback", rdata, 8'h03);

        // PRESCALE write with autoinc on (ptr 03 -> 04)
        do_addr(8'h03);
        do_we(8'h5A);
        chk("prescale_out", prescale, 8'h5A);
        tick();
        chk("autoinc_after_we", rdata, 8'h00);

        // Turn autoinc off, keep enable
        do_addr(8'h02);
        do_we(8'h01);

        // Clear sequence: count cycles with cnt_clear / busy high
        do_addr(8'h01);
        do_we(8'h02);
        n_clr  = 0;
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_clear) n_clr++;
            if (busy) n_busy++;
            tick();
        end
        $display("[TB] clear: cnt_clear high %0d cycles, busy high %0d cycles", n_clr, n_busy);
        chk("clear_len", n_clr,  4);
        chk("busy_len",  n_busy, 4);

        // Second clear while busy is ignored and flags err
        do_we(8'h02);
        chk("clr2_busy", busy, 1'b1);
        do_we(8'h02);
        tick();
        chk("status_err_busy", rdata, 8'h06);
        repeat (6) tick();
        chk("clear_done", cnt_clear, 1'b0);

        // Snapshot capture and byte-wise readback with autoinc
        count_in = 32'hDEADBEEF;
        do_we(8'h04);
        count_in = 32'h12345678;
        do_addr(8'h02);
        do_we(8'h03);
        do_addr(8'h04);
        tick();
        exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("snap_byte%0d", i), rdata, exp_bytes[i]);
            do_rd();
            tick();
        end
        chk("ptr_after_pops", rdata, 8'h00);
        do_addr(8'h01);
        tick();
        chk("status_snap_valid", rdata[0], 1'b1);
        chk("status_after_snap", rdata, 8'h05);

        // Pointer wrap 0xFF -> 0x00 on a write with autoinc
        do_addr(8'hFF);
        do_we(8'h55);
        tick();
        chk("wrap_rdata", rdata, 8'hC3);

        // Coincident addr_we + we: write at old ptr, load new ptr, no inc
        do_addr(8'h02);
        address = 8'h03;
        addr_we = 1'b1;
        wdata   = 8'h55;
        we      = 1'b1;
        tick();
        addr_we = 1'b0;
        we      = 1'b0;
        $display("[TB] addr_we 0x03 + we 0x55");
        tick();
        chk("coinc_ptr_prescale", rdata, 8'h5A);
        chk("coinc_enable", cnt_enable, 1'b1);
        do_addr(8'h02);
        tick();
        chk("coinc_ctrl", rdata, 8'h55);

        // Soft reset in the middle of a clear
        do_addr(8'h01);
        do_we(8'h02);
        chk("sr_busy_before", busy, 1'b1);
        do_we(8'h01);
        chk("sr_cnt_clear", cnt_clear, 1'b0);
        chk("sr_busy",      busy,      1'b0);
        chk("sr_enable",    cnt_enable, 1'b0);
        chk("sr_prescale",  prescale,  8'h00);
        tick();
        chk("sr_rdata_id",  rdata,     8'hC3);
        do_addr(8'h01);
        tick();
        chk("sr_status",    rdata,     8'h00);
        do_addr(8'h04);
        tick();
        chk("sr_snap_zero", rdata,     8'h00);

        // Clear + snapshot in one write: clear wins, err set
        do_addr(8'h01);
        count_in = 32'hCAFEF00D;
        do_we(8'h06);
        chk("cs_busy", busy, 1'b1);
        repeat (6) tick();
        chk("cs_status", rdata, 8'h04);
        do_addr(8'h04);
        tick();
        chk("cs_no_snap", rdata, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
